writeback_arbiter: RTL
======================

Name: writeback_arbiter

Overview:
Owns the single register-file write port behind the MemoryWriteback register. It merges the in-order pipeline writeback (memory data or ALU result, selected by wbs) with results from an auxiliary multi-cycle unit (divider/load helper), which are buffered in a small FIFO. The pipeline always has priority. An auxiliary entry blocked for too long forces a one-slot pipeline stall so that entry can drain.

Parameters:
DATA_W, 16, register data width
ADDR_W, 4, register index width
DEPTH, 4, aux FIFO entries (power of two, >=2)
STARVE_LIMIT, 8, consecutive blocked cycles before a forced stall (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
wb_valid  in  1  pipeline writeback slot carries a register write (ni/bubble already removed upstream)
wbs  in  1  pipeline source select: 0 = wb_mem_data, 1 = wb_calc_data
wb_mem_data  in  DATA_W  memory-read data from MemoryWriteback register
wb_calc_data  in  DATA_W  ALU result from MemoryWriteback register
wb_rd  in  ADDR_W  pipeline destination register
aux_valid  in  1  aux unit offers a result
aux_ready  out  1  FIFO can accept (registered, = !full)
aux_rd  in  ADDR_W  aux destination register
aux_data  in  DATA_W  aux result
rf_we  out  1  register-file write enable
rf_waddr  out  ADDR_W  write address
rf_wdata  out  DATA_W  write data
aux_grant  out  1  head aux entry written this cycle
stall_pipe  out  1  request that the pipeline issue a bubble
pending  out  1  FIFO non-empty

Behaviour:
- Reset (async, rst_n=0): FIFO empty, wait_cnt=0, state IDLE. Outputs: aux_ready=1, stall_pipe=0, pending=0. rf_we/aux_grant follow the combinational rules below and are 0 while the FIFO is empty and wb_valid=0.
- Aux push when aux_valid & aux_ready at the clock edge; the entry is visible at the head the next cycle. Minimum aux latency is 1 cycle.
- Write port (combinational):
  - wb_valid=1: rf_we=1, rf_waddr=wb_rd, rf_wdata = wbs ? wb_calc_data : wb_mem_data. aux_grant=0.
  - wb_valid=0 and FIFO non-empty: rf_we=1, write the head entry, aux_grant=1, pop at the edge.
  - Otherwise rf_we=0, rf_waddr=0, rf_wdata=0.
- Push and pop in the same cycle are both honoured; count is unchanged.
- aux_ready is computed from the next count, so it deasserts in the cycle after the FIFO becomes full.
- Entries retire strictly in FIFO order.
- FSM:
  - IDLE (empty): on push -> PEND, wait_cnt=0.
  - PEND: aux_grant -> wait_cnt=0, stay in PEND if entries remain, else IDLE. Blocked (wb_valid=1) -> wait_cnt+1; when wait_cnt+1 == STARVE_LIMIT -> FORCE.
  - FORCE: stall_pipe=1 (Moore). Stays in FORCE while wb_valid=1. The first grant -> wait_cnt=0, then PEND or IDLE by remaining count.
- Ordering hazards (same rd in pipeline and FIFO) are resolved by the hazard unit via pending/aux_rd; this block does not check them.
- Reset asserted mid-operation discards all FIFO contents immediately and drops stall_pipe.

Decomposition:
- Package wb_arb_pkg: typedef wb_arb_state_e {IDLE, PEND, FORCE}; entry struct {rd, data}; default width constants.
- One sub-module: wb_arb_fifo (DEPTH-entry synchronous FIFO with count, full, empty, head outputs). The FSM, counter and mux sit in the top module.

Test Plan:
- Reset: rst_n=0 mid-stream with 2 entries queued -> immediately pending=0, aux_ready=1, stall_pipe=0. After release, rf_we=0 with no inputs.
- Pipeline select: wb_valid=1, wbs=1, calc=FF00, mem=00FF, rd=3 -> rf_we=1, rf_waddr=3, rf_wdata=FF00. With wbs=0 -> rf_wdata=00FF.
- Aux idle slot: push rd=5, data=AAAA with wb_valid=0 -> next cycle rf_we=1, addr 5, data AAAA, aux_grant=1, pending=0 after the edge.
- Full FIFO: wb_valid held at 1, push 4 entries -> aux_ready=0 after the 4th. A 5th aux_valid is not accepted. Drain then produces entries in push order.
- Starvation: 1 entry queued, wb_valid=1 continuously -> stall_pipe=1 exactly STARVE_LIMIT (8) cycles after the entry reaches the head. Drop wb_valid -> grant, stall_pipe=0 the next cycle.
- Simultaneous push/pop: FIFO holds 2 entries, wb_valid=0, aux_valid=1 -> pop head and push new in one cycle, count stays 2, order preserved.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and default sizes for the writeback arbiter
package wb_arb_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;
    localparam int DEPTH_DEF = 4;
    localparam int STARVE_LIMIT_DEF = 8;
    typedef enum logic [1:0] {IDLE, PEND, FORCE} wb_arb_state_e;
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] rd;
        logic [DATA_W_DEF-1:0] data;
    } wb_arb_entry_t;
endpackage

// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: pipeline, aux-unit and register-file write port signals
interface writeback_arbiter_if #(parameter int DATA_W = 16, parameter int ADDR_W = 4);
    logic              wb_valid;
    logic              wbs;
    logic [DATA_W-1:0] wb_mem_data;
    logic [DATA_W-1:0] wb_calc_data;
    logic [ADDR_W-1:0] wb_rd;
    logic              aux_valid;
    logic              aux_ready;
    logic [ADDR_W-1:0] aux_rd;
    logic [DATA_W-1:0] aux_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              aux_grant;
    logic              stall_pipe;
    logic              pending;
    modport master (
        output wb_valid, wbs, wb_mem_data, wb_calc_data, wb_rd, aux_valid, aux_rd, aux_data,
        input  aux_ready, rf_we, rf_waddr, rf_wdata, aux_grant, stall_pipe, pending
    );
    modport slave (
        input  wb_valid, wbs, wb_mem_data, wb_calc_data, wb_rd, aux_valid, aux_rd, aux_data,
        output aux_ready, rf_we, rf_waddr, rf_wdata, aux_grant, stall_pipe, pending
    );
endinterface

// File: rtl/wb_arb_fifo.sv
// wb_arb_fifo: small synchronous FIFO holding queued aux results
module wb_arb_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W = ADDR_W_DEF + DATA_W_DEF,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rp;
    logic [PW-1:0] wp;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp <= '0;
            wp <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + PW'(1);
            if (pop) rp <= rp + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end
    assign head = mem[rp];
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges pipeline writeback with queued aux results onto one RF write port
module writeback_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input logic clk,
    input logic rst_n,
    writeback_arbiter_if.slave bus
);
    localparam int W = ADDR_W + DATA_W;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [WW-1:0] LIMIT = WW'(STARVE_LIMIT);
    wb_arb_state_e state;
    logic [WW-1:0] wait_cnt;
    logic [W-1:0]  head;
    logic [CW-1:0] count;
    logic full, empty, push, grant, remain;
    assign push = bus.aux_valid & bus.aux_ready;
    assign grant = !bus.wb_valid & !empty;
    assign remain = push | (count > CW'(1));
    wb_arb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(grant),
        .din({bus.aux_rd, bus.aux_data}), .head(head),
        .count(count), .full(full), .empty(empty)
    );
    assign bus.aux_ready = !full;
    assign bus.pending = !empty;
    assign bus.aux_grant = grant;
    assign bus.rf_we = bus.wb_valid | !empty;
    assign bus.rf_waddr = bus.wb_valid ? bus.wb_rd : grant ? head[W-1:DATA_W] : '0;
    assign bus.rf_wdata = bus.wb_valid ? (bus.wbs ? bus.wb_calc_data : bus.wb_mem_data)
                        : grant ? head[DATA_W-1:0] : '0;
    // Blocked head entry ages until it forces a pipeline bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            wait_cnt <= '0;
            bus.stall_pipe <= 1'b0;
        end else begin
            case (state)
                IDLE: if (push) begin
                    state <= PEND;
                    wait_cnt <= '0;
                end
                PEND: if (grant) begin
                    wait_cnt <= '0;
                    state <= remain ? PEND : IDLE;
                end else if (bus.wb_valid) begin
                    wait_cnt <= wait_cnt + WW'(1);
                    if (wait_cnt + WW'(1) == LIMIT) begin
                        state <= FORCE;
                        bus.stall_pipe <= 1'b1;
                    end
                end
                FORCE: if (grant) begin
                    wait_cnt <= '0;
                    state <= remain ? PEND : IDLE;
                    bus.stall_pipe <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    bus.stall_pipe <= 1'b0;
                end
            endcase
        end
    end
endmodule
